// File: rtl/sha_pkg.sv
// Shared types and constants for the hash-core sequencers.
// Round counts and digest size for SHA-256 / SHA-512.
package sha_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    READ = 2'd2
  } state_e;

  localparam int SHA256_ROUNDS = 64;
  localparam int SHA512_ROUNDS = 80;
  localparam int DIGEST_WORDS  = 8;

endpackage

// File: rtl/modn_counter.sv
// Modulo-N up counter with sync clear, enable and terminal flag.
// Wraps by explicit compare against N-1, never by binary overflow.
module modn_counter #(
  parameter  int N = 8,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc  = (cnt_q == W'(N - 1));
  assign cnt = cnt_q;

  // next count: clear wins, then step or wrap at terminal count
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + W'(1);
    end
  end

  // count register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/round_addr_sequencer.sv
// Round-address and digest-readout sequencer for the hash cores.
// Outputs decode only from registered state; no input-to-output path.
module round_addr_sequencer
  import sha_pkg::*;
#(
  parameter  int ROUNDS     = 64,
  parameter  int OUT_WORDS  = 8,
  parameter  int AUTO_START = 1,
  parameter  int RD_WRAP    = 0,
  localparam int AW = $clog2(ROUNDS),
  localparam int OW = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1
) (
  input  logic          clk,
  input  logic          soc_n,
  input  logic          start,
  input  logic          adv,
  input  logic          rd,
  output logic [AW-1:0] addr,
  output logic          rnd_valid,
  output logic          eoc,
  output logic [OW-1:0] rd_addr,
  output logic          rd_last,
  output logic          busy
);

  state_e state_q;
  state_e state_d;

  logic rnd_tc;
  logic rd_tc;
  logic in_run;
  logic in_read;

  assign in_run  = (state_q == RUN);
  assign in_read = (state_q == READ);

  // round counter parks at 0 outside RUN, so READ sees addr=0
  modn_counter #(.N(ROUNDS)) u_rnd (
    .clk   (clk),
    .rst_n (soc_n),
    .clr   (start || !in_run),
    .en    (in_run && adv),
    .cnt   (addr),
    .tc    (rnd_tc)
  );

  // readout counter parks at 0 outside READ
  modn_counter #(.N(OUT_WORDS)) u_rd (
    .clk   (clk),
    .rst_n (soc_n),
    .clr   (start || !in_read),
    .en    (in_read && rd),
    .cnt   (rd_addr),
    .tc    (rd_tc)
  );

  // next state: start aborts anything, else walk RUN -> READ -> IDLE
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          if (adv && rnd_tc) state_d = READ;
        end
        READ: begin
          if (rd && rd_tc && (RD_WRAP == 0)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state register; reset lands in RUN or IDLE depending on AUTO_START
  always_ff @(posedge clk) begin
    if (!soc_n) begin
      state_q <= (AUTO_START != 0) ? RUN : IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign rnd_valid = in_run;
  assign eoc       = in_read;
  assign busy      = in_run || in_read;
  assign rd_last   = in_read && rd_tc;

endmodule

// File: tb/tb_round_addr_sequencer.sv
// Directed bench for round_addr_sequencer.
// dut_a: 64 rounds, auto start, no wrap; dut_b: 80 rounds, manual start, wrap.
module tb_round_addr_sequencer;
  import sha_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       soc_n_a, start_a, adv_a, rd_a;
  logic [5:0] addr_a;
  logic [2:0] rd_addr_a;
  logic       rnd_valid_a, eoc_a, rd_last_a, busy_a;

  logic       soc_n_b, start_b, adv_b, rd_b;
  logic [6:0] addr_b;
  logic [2:0] rd_addr_b;
  logic       rnd_valid_b, eoc_b, rd_last_b, busy_b;

  int n_vec = 0;
  int n_err = 0;

  round_addr_sequencer #(
    .ROUNDS(SHA256_ROUNDS), .OUT_WORDS(DIGEST_WORDS),
    .AUTO_START(1), .RD_WRAP(0)
  ) dut_a (
    .clk(clk), .soc_n(soc_n_a), .start(start_a), .adv(adv_a), .rd(rd_a),
    .addr(addr_a), .rnd_valid(rnd_valid_a), .eoc(eoc_a),
    .rd_addr(rd_addr_a), .rd_last(rd_last_a), .busy(busy_a)
  );

  round_addr_sequencer #(
    .ROUNDS(SHA512_ROUNDS), .OUT_WORDS(DIGEST_WORDS),
    .AUTO_START(0), .RD_WRAP(1)
  ) dut_b (
    .clk(clk), .soc_n(soc_n_b), .start(start_b), .adv(adv_b), .rd(rd_b),
    .addr(addr_b), .rnd_valid(rnd_valid_b), .eoc(eoc_b),
    .rd_addr(rd_addr_b), .rd_last(rd_last_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    soc_n_a = 1'b0; start_a = 1'b0; adv_a = 1'b1; rd_a = 1'b0;
    soc_n_b = 1'b0; start_b = 1'b0; adv_b = 1'b0; rd_b = 1'b0;
    tick();

    // reset state
    chk("a_rst_addr", 32'(addr_a), 0);
    chk("a_rst_valid", 32'(rnd_valid_a), 1);
    chk("a_rst_eoc", 32'(eoc_a), 0);
    chk("b_rst_busy", 32'(busy_b), 0);
    chk("b_rst_valid", 32'(rnd_valid_b), 0);
    chk("b_rst_addr", 32'(addr_b), 0);

    // test 1: 64 rounds back to back
    soc_n_a = 1'b1;
    soc_n_b = 1'b1;
    adv_b = 1'b1;
    rd_b = 1'b1;
    for (int i = 0; i < 64; i++) begin
      chk("a_run_addr", 32'(addr_a), 32'(i));
      chk("a_run_valid", 32'(rnd_valid_a), 1);
      tick();
    end
    chk("a_eoc", 32'(eoc_a), 1);
    chk("a_eoc_addr", 32'(addr_a), 0);
    chk("a_eoc_valid", 32'(rnd_valid_a), 0);
    chk("a_eoc_rdaddr", 32'(rd_addr_a), 0);
    chk("b_idle_ign", 32'(busy_b), 0);
    chk("b_idle_addr", 32'(addr_b), 0);

    // test 3: readout without wrap, then IDLE
    rd_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("a_rd_addr", 32'(rd_addr_a), 32'(i));
      chk("a_rd_last", 32'(rd_last_a), (i == 7) ? 1 : 0);
      chk("a_rd_eoc", 32'(eoc_a), 1);
      tick();
    end
    rd_a = 1'b0;
    chk("a_done_busy", 32'(busy_a), 0);
    chk("a_done_eoc", 32'(eoc_a), 0);
    chk("a_done_rdaddr", 32'(rd_addr_a), 0);
    chk("a_done_valid", 32'(rnd_valid_a), 0);

    // test 5: start from IDLE, abort at 37, abort in READ
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("a_start_addr", 32'(addr_a), 0);
    chk("a_start_valid", 32'(rnd_valid_a), 1);
    for (int i = 0; i < 37; i++) tick();
    chk("a_at37", 32'(addr_a), 37);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("a_abort_addr", 32'(addr_a), 0);
    chk("a_abort_valid", 32'(rnd_valid_a), 1);
    chk("a_abort_eoc", 32'(eoc_a), 0);
    for (int i = 0; i < 64; i++) tick();
    chk("a_read2_eoc", 32'(eoc_a), 1);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("a_rabort_addr", 32'(addr_a), 0);
    chk("a_rabort_valid", 32'(rnd_valid_a), 1);
    chk("a_rabort_eoc", 32'(eoc_a), 0);
    chk("a_rabort_rd", 32'(rd_addr_a), 0);

    // test 2: 80 rounds with adv toggling 1/0
    rd_b = 1'b0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("b_start_valid", 32'(rnd_valid_b), 1);
    for (int k = 0; k < 159; k++) begin
      adv_b = ((k % 2) == 0);
      chk("b_tog_addr", 32'(addr_b), 32'((k + 1) / 2));
      chk("b_tog_eoc", 32'(eoc_b), 0);
      tick();
    end
    adv_b = 1'b0;
    chk("b_eoc", 32'(eoc_b), 1);
    chk("b_eoc_addr", 32'(addr_b), 0);
    chk("b_eoc_valid", 32'(rnd_valid_b), 0);

    // test 4: readout with wrap, 10 pulses
    rd_b = 1'b1;
    for (int j = 0; j < 10; j++) begin
      chk("b_wrap_addr", 32'(rd_addr_b), 32'(j % 8));
      chk("b_wrap_eoc", 32'(eoc_b), 1);
      tick();
    end
    chk("b_wrap_end", 32'(rd_addr_b), 2);
    chk("b_wrap_busy", 32'(busy_b), 1);
    chk("b_wrap_eoc2", 32'(eoc_b), 1);

    // test 6: reset mid-READ beats rd and start
    soc_n_b = 1'b0;
    start_b = 1'b1;
    tick();
    soc_n_b = 1'b1;
    start_b = 1'b0;
    rd_b = 1'b0;
    chk("b_r6_busy", 32'(busy_b), 0);
    chk("b_r6_eoc", 32'(eoc_b), 0);
    chk("b_r6_addr", 32'(addr_b), 0);
    chk("b_r6_rdaddr", 32'(rd_addr_b), 0);
    chk("b_r6_valid", 32'(rnd_valid_b), 0);
    tick();
    chk("b_r6_idle", 32'(busy_b), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
